// File: rtl/lap_controller.sv
// Stopwatch lap controller: run/pause/recall FSM, lap register file and display mux.
// All outputs registered except count_en; the time counter is never wrapped past 9999.
module lap_controller #(
  parameter int LAP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_pause,
  input  logic        clear,
  input  logic        lap,
  input  logic        recall,
  input  logic [15:0] time_in,
  output logic        count_en,
  output logic        count_clr,
  output logic [15:0] disp_time,
  output logic [2:0]  disp_lap,
  output logic [2:0]  lap_count,
  output logic        lap_full,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSE  = 2'b10,
    RECALL = 2'b11
  } state_t;

  localparam logic [15:0] SAT_TIME = 16'h9999;
  localparam logic [2:0]  DEPTH    = 3'(LAP_DEPTH);

  state_t      cur_state, nxt_state;
  logic [2:0]  nxt_disp;
  logic        store, drop;
  logic [15:0] rd_dat;
  logic [15:0] laps [LAP_DEPTH];

  assign state    = cur_state;
  assign count_en = (cur_state == RUN) && (time_in != SAT_TIME);

  always_comb begin
    nxt_state = cur_state;
    nxt_disp  = disp_lap;
    store     = 1'b0;
    drop      = 1'b0;
    if (clear) begin
      nxt_state = IDLE;
      nxt_disp  = 3'd0;
    end else begin
      case (cur_state)
        IDLE: if (start_pause) nxt_state = RUN;
        RUN: begin
          if (start_pause || time_in == SAT_TIME) nxt_state = PAUSE;
          if (lap) begin
            if (lap_count < DEPTH) store = 1'b1;
            else                   drop  = 1'b1;
          end
        end
        PAUSE: begin
          if (start_pause) begin
            nxt_state = RUN;
          end else if (recall && lap_count != 3'd0) begin
            nxt_state = RECALL;
            nxt_disp  = 3'd1;
          end
        end
        RECALL: begin
          // start_pause leaves recall but deliberately does not resume counting
          if (start_pause) begin
            nxt_state = PAUSE;
            nxt_disp  = 3'd0;
          end else if (recall) begin
            if (disp_lap < lap_count) begin
              nxt_disp = disp_lap + 3'd1;
            end else begin
              nxt_state = PAUSE;
              nxt_disp  = 3'd0;
            end
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  // Display source follows the index being registered this edge; entry k lives at laps[k-1]
  always_comb begin
    rd_dat = time_in;
    for (int i = 0; i < LAP_DEPTH; i++) begin
      if (nxt_disp == 3'(i + 1)) rd_dat = laps[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= IDLE;
      disp_lap  <= 3'd0;
      disp_time <= 16'h0000;
      count_clr <= 1'b0;
      lap_count <= 3'd0;
      lap_full  <= 1'b0;
      for (int i = 0; i < LAP_DEPTH; i++) laps[i] <= 16'h0000;
    end else begin
      cur_state <= nxt_state;
      disp_lap  <= nxt_disp;
      disp_time <= rd_dat;
      count_clr <= clear;
      if (clear) begin
        lap_count <= 3'd0;
        lap_full  <= 1'b0;
      end else begin
        if (store) lap_count <= lap_count + 3'd1;
        if (drop)  lap_full  <= 1'b1;
      end
      for (int i = 0; i < LAP_DEPTH; i++) begin
        if (store && lap_count == 3'(i)) laps[i] <= time_in;
      end
    end
  end

endmodule

// File: tb/tb_lap_controller.sv
// Directed vector bench for lap_controller (LAP_DEPTH=4).
module tb_lap_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_pause, clear, lap, recall;
  logic [15:0] time_in;
  logic        count_en, count_clr;
  logic [15:0] disp_time;
  logic [2:0]  disp_lap, lap_count;
  logic        lap_full;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  lap_controller #(.LAP_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start_pause(start_pause), .clear(clear), .lap(lap),
    .recall(recall), .time_in(time_in), .count_en(count_en), .count_clr(count_clr),
    .disp_time(disp_time), .disp_lap(disp_lap), .lap_count(lap_count),
    .lap_full(lap_full), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sp, clr, lp, rc;
    logic [15:0] t;
    logic [1:0]  e_state;
    logic [2:0]  e_dl, e_lc;
    logic        e_full;
    logic [15:0] e_dt;
    logic        e_cclr, e_cen;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic sp, clr, lp, rc, input logic [15:0] t,
                   input logic [1:0] st, input logic [2:0] dl, lc, input logic full,
                   input logic [15:0] dt, input logic cclr, cen);
    vec_t x;
    x.sp = sp; x.clr = clr; x.lp = lp; x.rc = rc; x.t = t;
    x.e_state = st; x.e_dl = dl; x.e_lc = lc; x.e_full = full;
    x.e_dt = dt; x.e_cclr = cclr; x.e_cen = cen;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [2:0] dl, lc,
                           input logic full, input logic [15:0] dt, input logic cclr, cen);
    chk({tag, ".state"},     16'(state),     16'(st));
    chk({tag, ".disp_lap"},  16'(disp_lap),  16'(dl));
    chk({tag, ".lap_count"}, 16'(lap_count), 16'(lc));
    chk({tag, ".lap_full"},  16'(lap_full),  16'(full));
    chk({tag, ".disp_time"}, disp_time,      dt);
    chk({tag, ".count_clr"}, 16'(count_clr), 16'(cclr));
    chk({tag, ".count_en"},  16'(count_en),  16'(cen));
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic sp, clr, lp, rc, input logic [15:0] t);
    @(negedge clk);
    start_pause = sp; clear = clr; lap = lp; recall = rc; time_in = t;
    @(posedge clk);
    #1;
    start_pause = 0; clear = 0; lap = 0; recall = 0;
  endtask

  initial begin
    rst = 1; start_pause = 0; clear = 0; lap = 0; recall = 0; time_in = 16'h0000;

    //  sp clr lap rec  time      state  dl    lc    full  disp     cclr cen
    v(1, 0, 0, 0, 16'h0000, 2'b01, 3'd0, 3'd0, 0, 16'h0000, 0, 1);
    v(0, 0, 0, 0, 16'h0010, 2'b01, 3'd0, 3'd0, 0, 16'h0010, 0, 1);
    v(0, 0, 1, 0, 16'h0123, 2'b01, 3'd0, 3'd1, 0, 16'h0123, 0, 1);
    v(0, 0, 0, 0, 16'h0200, 2'b01, 3'd0, 3'd1, 0, 16'h0200, 0, 1);
    v(0, 0, 1, 0, 16'h0456, 2'b01, 3'd0, 3'd2, 0, 16'h0456, 0, 1);
    v(1, 0, 0, 0, 16'h0500, 2'b10, 3'd0, 3'd2, 0, 16'h0500, 0, 0);
    v(0, 0, 1, 0, 16'h0500, 2'b10, 3'd0, 3'd2, 0, 16'h0500, 0, 0);  // lap ignored in PAUSE
    v(0, 0, 0, 1, 16'h0500, 2'b11, 3'd1, 3'd2, 0, 16'h0123, 0, 0);
    v(0, 0, 1, 0, 16'h0500, 2'b11, 3'd1, 3'd2, 0, 16'h0123, 0, 0);  // lap ignored in RECALL
    v(0, 0, 0, 1, 16'h0500, 2'b11, 3'd2, 3'd2, 0, 16'h0456, 0, 0);
    v(0, 0, 0, 1, 16'h0500, 2'b10, 3'd0, 3'd2, 0, 16'h0500, 0, 0);
    v(0, 0, 0, 1, 16'h0500, 2'b11, 3'd1, 3'd2, 0, 16'h0123, 0, 0);
    v(1, 0, 0, 1, 16'h0500, 2'b10, 3'd0, 3'd2, 0, 16'h0500, 0, 0);  // sp exits RECALL, no resume
    v(1, 0, 0, 1, 16'h0500, 2'b01, 3'd0, 3'd2, 0, 16'h0500, 0, 1);  // sp wins over recall
    v(1, 0, 1, 0, 16'h0600, 2'b10, 3'd0, 3'd3, 0, 16'h0600, 0, 0);  // lap+sp both act
    v(1, 0, 0, 0, 16'h0700, 2'b01, 3'd0, 3'd3, 0, 16'h0700, 0, 1);
    v(0, 0, 1, 0, 16'h0800, 2'b01, 3'd0, 3'd4, 0, 16'h0800, 0, 1);
    v(0, 0, 1, 0, 16'h0900, 2'b01, 3'd0, 3'd4, 1, 16'h0900, 0, 1);  // overflow
    v(1, 0, 0, 0, 16'h0900, 2'b10, 3'd0, 3'd4, 1, 16'h0900, 0, 0);
    v(0, 0, 0, 1, 16'h0900, 2'b11, 3'd1, 3'd4, 1, 16'h0123, 0, 0);
    v(0, 0, 0, 1, 16'h0900, 2'b11, 3'd2, 3'd4, 1, 16'h0456, 0, 0);
    v(0, 0, 0, 1, 16'h0900, 2'b11, 3'd3, 3'd4, 1, 16'h0600, 0, 0);
    v(0, 0, 0, 1, 16'h0900, 2'b11, 3'd4, 3'd4, 1, 16'h0800, 0, 0);
    v(0, 0, 0, 1, 16'h0900, 2'b10, 3'd0, 3'd4, 1, 16'h0900, 0, 0);
    v(0, 1, 0, 0, 16'h0900, 2'b00, 3'd0, 3'd0, 0, 16'h0900, 1, 0);  // clear from PAUSE
    v(0, 0, 0, 0, 16'h0900, 2'b00, 3'd0, 3'd0, 0, 16'h0900, 0, 0);
    v(0, 0, 0, 1, 16'h0900, 2'b00, 3'd0, 3'd0, 0, 16'h0900, 0, 0);  // recall ignored in IDLE
    v(0, 0, 1, 0, 16'h0900, 2'b00, 3'd0, 3'd0, 0, 16'h0900, 0, 0);  // lap ignored in IDLE
    v(1, 0, 0, 0, 16'h0100, 2'b01, 3'd0, 3'd0, 0, 16'h0100, 0, 1);
    v(0, 0, 1, 0, 16'h0111, 2'b01, 3'd0, 3'd1, 0, 16'h0111, 0, 1);
    v(0, 0, 1, 0, 16'h0222, 2'b01, 3'd0, 3'd2, 0, 16'h0222, 0, 1);
    v(1, 1, 1, 0, 16'h0333, 2'b00, 3'd0, 3'd0, 0, 16'h0333, 1, 0);  // clear has priority
    v(0, 0, 0, 0, 16'h0333, 2'b00, 3'd0, 3'd0, 0, 16'h0333, 0, 0);
    v(1, 0, 0, 0, 16'h0400, 2'b01, 3'd0, 3'd0, 0, 16'h0400, 0, 1);
    v(1, 0, 0, 0, 16'h0400, 2'b10, 3'd0, 3'd0, 0, 16'h0400, 0, 0);
    v(0, 0, 0, 1, 16'h0400, 2'b10, 3'd0, 3'd0, 0, 16'h0400, 0, 0);  // recall with no laps
    v(1, 0, 0, 0, 16'h9999, 2'b01, 3'd0, 3'd0, 0, 16'h9999, 0, 0);  // RUN at saturation
    v(1, 0, 0, 0, 16'h9999, 2'b10, 3'd0, 3'd0, 0, 16'h9999, 0, 0);  // sat + sp -> PAUSE
    v(1, 0, 0, 0, 16'h1000, 2'b01, 3'd0, 3'd0, 0, 16'h1000, 0, 1);
    v(0, 0, 1, 0, 16'h1111, 2'b01, 3'd0, 3'd1, 0, 16'h1111, 0, 1);
    v(0, 0, 1, 0, 16'h2222, 2'b01, 3'd0, 3'd2, 0, 16'h2222, 0, 1);

    #12;
    check_all("reset", 2'b00, 3'd0, 3'd0, 0, 16'h0000, 0, 0);
    @(negedge clk);
    rst = 0;

    foreach (vecs[i]) begin
      step(vecs[i].sp, vecs[i].clr, vecs[i].lp, vecs[i].rc, vecs[i].t);
      check_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_dl, vecs[i].e_lc,
                vecs[i].e_full, vecs[i].e_dt, vecs[i].e_cclr, vecs[i].e_cen);
    end

    // Saturation mid-run: count_en drops combinationally before the edge
    @(negedge clk);
    time_in = 16'h9999;
    #1;
    chk("sat.count_en_same_cycle", 16'(count_en), 16'd0);
    chk("sat.state_before_edge", 16'(state), 16'(2'b01));
    @(posedge clk);
    #1;
    chk("sat.state_after_edge", 16'(state), 16'(2'b10));
    chk("sat.disp_time", disp_time, 16'h9999);

    // Into RECALL at disp_lap=2, then async reset between edges
    step(0, 0, 0, 1, 16'h9999);
    step(0, 0, 0, 1, 16'h9999);
    check_all("recall2", 2'b11, 3'd2, 3'd2, 0, 16'h2222, 0, 0);
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    check_all("async_rst", 2'b00, 3'd0, 3'd0, 0, 16'h0000, 0, 0);

    // First start_pause after reset release is honoured
    @(negedge clk);
    rst = 0;
    step(1, 0, 0, 0, 16'h0050);
    check_all("post_rst_sp", 2'b01, 3'd0, 3'd0, 0, 16'h0050, 0, 1);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 0, 16'(16'h0051 + k));
      chk($sformatf("run_hold%0d.state", k), 16'(state), 16'(2'b01));
      chk($sformatf("run_hold%0d.count_en", k), 16'(count_en), 16'd1);
    end
    step(1, 0, 0, 0, 16'h0070);
    check_all("pause_again", 2'b10, 3'd0, 3'd0, 0, 16'h0070, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
